// File: rtl/disc_plotter_if.sv
// disc_plotter_if: request and pixel-bus bundle for disc_plotter.
//   Request side : go, row, column, player, clear   (driven by the game FSM)
//   Pixel side   : x, y, colour, plot               (feeds the VGA adapter write port)
//   Status       : busy, done
// Modports: master = game FSM / bench view, slave = plotter view.
interface disc_plotter_if;
  logic       go;
  logic [2:0] row;
  logic [2:0] column;
  logic       player;
  logic       clear;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output go, row, column, player, clear,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  go, row, column, player, clear,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/disc_plotter.sv
// disc_plotter: pixel renderer for a 7x6 board. A go pulse paints one cell in the
// player's colour; a clear request repaints the whole board area in background colour.
// One pixel per clock leaves on the x/y/colour/plot bus.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low reset
//   bus   - disc_plotter_if.slave (go/row/column/player/clear in;
//           x/y/colour/plot/busy/done out, all registered)
// Build option: define DISC_ROUND_EN to paint pixels outside the cell's inscribed
// circle in background colour (round discs); otherwise the full square is filled.
module disc_plotter #(
  parameter int unsigned CELL_W   = 16,
  parameter int unsigned CELL_H   = 16,
  parameter int unsigned X_ORIGIN = 24,
  parameter int unsigned Y_ORIGIN = 12,
  parameter logic [2:0]  COL_P0   = 3'b100,
  parameter logic [2:0]  COL_P1   = 3'b110,
  parameter logic [2:0]  COL_BG   = 3'b001
) (
  input logic            clk,
  input logic            reset,
  disc_plotter_if.slave  bus
);

  localparam logic [7:0] XOrg       = 8'(X_ORIGIN);
  localparam logic [6:0] YOrg       = 7'(Y_ORIGIN);
  localparam logic [7:0] CellW8     = 8'(CELL_W);
  localparam logic [6:0] CellH7     = 7'(CELL_H);
  localparam logic [7:0] DxLastDraw = 8'(CELL_W - 1);
  localparam logic [6:0] DyLastDraw = 7'(CELL_H - 1);
  localparam logic [7:0] DxLastClr  = 8'(7 * CELL_W - 1);
  localparam logic [6:0] DyLastClr  = 7'(6 * CELL_H - 1);

  typedef enum logic [1:0] {StIdle, StDraw, StClear, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] dx_q, dx_d;
  logic [6:0] dy_q, dy_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [2:0] fill_q, fill_d;

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       cell_ok;
  logic       scanning;
  logic [7:0] dx_last;
  logic [6:0] dy_last;
  logic       row_end;
  logic       scan_end;
  logic [2:0] pixel_colour;

  assign cell_ok  = (bus.row <= 3'd5) && (bus.column <= 3'd6);
  assign scanning = (state_q == StDraw) || (state_q == StClear);
  assign dx_last  = (state_q == StClear) ? DxLastClr : DxLastDraw;
  assign dy_last  = (state_q == StClear) ? DyLastClr : DyLastDraw;
  assign row_end  = (dx_q == dx_last);
  assign scan_end = row_end && (dy_q == dy_last);

`ifdef DISC_ROUND_EN
  // Distances are doubled so the cell centre sits on an integer grid point.
  localparam logic signed [9:0]  CwM1   = 10'(CELL_W - 1);
  localparam logic signed [9:0]  ChM1   = 10'(CELL_H - 1);
  localparam logic        [20:0] RadSq  = 21'(CELL_W * CELL_W);

  logic signed [9:0]  ex, ey;
  logic signed [19:0] ex_sq, ey_sq;
  logic        [20:0] dist_sq;
  logic               in_disc;

  always_comb begin
    ex      = $signed({1'b0, dx_q, 1'b0}) - CwM1;
    ey      = $signed({2'b00, dy_q, 1'b0}) - ChM1;
    ex_sq   = ex * ex;
    ey_sq   = ey * ey;
    dist_sq = {1'b0, $unsigned(ex_sq)} + {1'b0, $unsigned(ey_sq)};
    in_disc = (dist_sq <= RadSq);
  end

  assign pixel_colour = ((state_q == StDraw) && !in_disc) ? COL_BG : fill_q;
`else
  assign pixel_colour = fill_q;
`endif

  // Next-state: request decode, scan counters and latched drawing context.
  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    fill_d   = fill_q;
    unique case (state_q)
      StIdle: begin
        // clear takes priority; a coincident go is dropped.
        if (bus.clear) begin
          state_d  = StClear;
          dx_d     = '0;
          dy_d     = '0;
          base_x_d = XOrg;
          base_y_d = YOrg;
          fill_d   = COL_BG;
        end else if (bus.go && cell_ok) begin
          state_d  = StDraw;
          dx_d     = '0;
          dy_d     = '0;
          base_x_d = XOrg + 8'(bus.column) * CellW8;
          base_y_d = YOrg + 7'(bus.row) * CellH7;
          fill_d   = bus.player ? COL_P1 : COL_P0;
        end
      end
      StDraw, StClear: begin
        if (row_end) begin
          dx_d = '0;
          if (scan_end) begin
            dy_d    = '0;
            state_d = StDone;
          end else begin
            dy_d = dy_q + 7'd1;
          end
        end else begin
          dx_d = dx_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output stage: the pixel addressed by the counters this cycle is presented next cycle.
  always_comb begin
    plot_d   = scanning;
    busy_d   = scanning;
    done_d   = (state_q == StDone);
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (scanning) begin
      x_d      = base_x_q + dx_q;
      y_d      = base_y_q + dy_q;
      colour_d = pixel_colour;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      dx_q     <= '0;
      dy_q     <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      fill_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      fill_q   <= fill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_disc_plotter.sv
// Self-checking bench for disc_plotter: directed and random requests compared against
// a pixel-list reference model built from the board geometry.
module tb_disc_plotter;

  localparam int CELL_W   = 16;
  localparam int CELL_H   = 16;
  localparam int X_ORIGIN = 24;
  localparam int Y_ORIGIN = 12;
  localparam int COL_P0   = 3'b100;
  localparam int COL_P1   = 3'b110;
  localparam int COL_BG   = 3'b001;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  disc_plotter_if bus ();

  disc_plotter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_x"},      32'(bus.x),      32'd0);
    check({tag, "_y"},      32'(bus.y),      32'd0);
    check({tag, "_colour"}, 32'(bus.colour), 32'd0);
    check({tag, "_plot"},   32'(bus.plot),   32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
  endtask

  // Expected pixel stream for one request, straight from the board geometry.
  task automatic build_model(input bit g, input bit clr, input int r, input int c,
                             input bit p, output pix_t q[$]);
    int bx, by, w, h, pc;
    pix_t px;
    q = {};
    if (clr) begin
      bx = X_ORIGIN; by = Y_ORIGIN; w = 7 * CELL_W; h = 6 * CELL_H; pc = COL_BG;
    end else if (g && r <= 5 && c <= 6) begin
      bx = X_ORIGIN + c * CELL_W; by = Y_ORIGIN + r * CELL_H;
      w = CELL_W; h = CELL_H; pc = p ? COL_P1 : COL_P0;
    end else begin
      return;
    end
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        px.x = (bx + i) % 256;
        px.y = (by + j) % 128;
        px.c = pc;
`ifdef DISC_ROUND_EN
        if (!clr) begin
          int d;
          d = (2 * i - (CELL_W - 1)) * (2 * i - (CELL_W - 1))
            + (2 * j - (CELL_H - 1)) * (2 * j - (CELL_H - 1));
          if (d > CELL_W * CELL_W) px.c = COL_BG;
        end
`endif
        q.push_back(px);
      end
    end
  endtask

  // Call at a negedge. Issues one request and watches the bus for a bounded window.
  task automatic run_op(input string tag, input bit g, input bit clr, input int r,
                        input int c, input bit p, input int second_at);
    pix_t exp_q[$];
    pix_t first_px, last_px;
    int   n_plot, n_done, done_cyc, first_cyc, pix_err, busy_err, limit;
    build_model(g, clr, r, c, p, exp_q);
    n_plot = 0; n_done = 0; done_cyc = -1; first_cyc = -1; pix_err = 0; busy_err = 0;
    first_px = '{-1, -1, -1};
    last_px  = '{-1, -1, -1};
    bus.go = g; bus.clear = clr;
    bus.row = 3'(r); bus.column = 3'(c); bus.player = p;
    @(negedge clk);
    // Scramble the request inputs so anything not latched at the go edge shows up.
    bus.go = 1'b0; bus.clear = 1'b0;
    bus.row = 3'($urandom_range(0, 5)); bus.column = 3'($urandom_range(0, 6));
    bus.player = ~p;
    limit = (exp_q.size() + 12 > 40) ? exp_q.size() + 12 : 40;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (bus.plot === 1'b1) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_px  = '{int'(bus.x), int'(bus.y), int'(bus.colour)};
        end
        last_px = '{int'(bus.x), int'(bus.y), int'(bus.colour)};
        if (n_plot >= exp_q.size()) pix_err++;
        else if (int'(bus.x) != exp_q[n_plot].x || int'(bus.y) != exp_q[n_plot].y ||
                 int'(bus.colour) != exp_q[n_plot].c) pix_err++;
        n_plot++;
      end
      if (bus.busy !== bus.plot) busy_err++;
      if (bus.done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      bus.go = (cyc == second_at);
    end
    bus.go = 1'b0;
    check({tag, "_plot_count"}, 32'(n_plot), 32'(exp_q.size()));
    check({tag, "_done_count"}, 32'(n_done), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check({tag, "_pixel_errors"}, 32'(pix_err), 32'd0);
    check({tag, "_busy_errors"}, 32'(busy_err), 32'd0);
    if (exp_q.size() > 0) begin
      check({tag, "_first_cycle"}, 32'(first_cyc), 32'd1);
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_q.size() + 1));
      check({tag, "_first_x"}, 32'(first_px.x), 32'(exp_q[0].x));
      check({tag, "_first_y"}, 32'(first_px.y), 32'(exp_q[0].y));
      check({tag, "_last_x"}, 32'(last_px.x), 32'(exp_q[exp_q.size() - 1].x));
      check({tag, "_last_y"}, 32'(last_px.y), 32'(exp_q[exp_q.size() - 1].y));
      check({tag, "_last_colour"}, 32'(last_px.c), 32'(exp_q[exp_q.size() - 1].c));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.go = 1'b0; bus.clear = 1'b0; bus.row = '0; bus.column = '0; bus.player = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_initial");
    reset = 1'b1;
    @(negedge clk);

    // Start a draw, then pull reset asynchronously mid-scan.
    bus.go = 1'b1; bus.row = 3'd2; bus.column = 3'd3; bus.player = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_draw_plot_active", 32'(bus.plot), 32'd1);
    #2 reset = 1'b0;
    #1 check_outputs_zero("reset_mid_draw");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_reset_idle");

    run_op("draw_r5_c0_p0", 1'b1, 1'b0, 5, 0, 1'b0, -1);
    run_op("draw_r0_c6_p1", 1'b1, 1'b0, 0, 6, 1'b1, -1);
    run_op("bad_col7", 1'b1, 1'b0, 0, 7, 1'b0, -1);
    run_op("bad_row6", 1'b1, 1'b0, 6, 0, 1'b1, -1);
    run_op("go_and_clear", 1'b1, 1'b1, 1, 1, 1'b1, -1);
    run_op("second_go_ignored", 1'b1, 1'b0, 2, 3, 1'b0, 10);
    run_op("draw_r0_c0_p0", 1'b1, 1'b0, 0, 0, 1'b0, -1);

    for (int k = 0; k < 6; k++) begin
      int r, c;
      bit p;
      r = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      p = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d_r%0d_c%0d", k, r, c), 1'b1, 1'b0, r, c, p, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/disc_plotter.md
# disc_plotter

Pixel-level renderer between the game FSM and the VGA adapter. On a single-cycle `go` from the FSM it paints one cell of the 7×6 board in the current player's colour. On a `clear` request it repaints the whole board area in background colour. It emits one pixel per clock on an `x`/`y`/`colour`/`plot` bus that feeds the VGA adapter's write port.

## Interface
Parameters:
- `CELL_W`, 16: cell width in pixels (power of two).
- `CELL_H`, 16: cell height in pixels (power of two).
- `X_ORIGIN`, 24: x of board's left edge.
- `Y_ORIGIN`, 12: y of board's top edge.
- `COL_P0`, 3'b100: player-0 colour (red).
- `COL_P1`, 3'b110: player-1 colour (yellow).
- `COL_BG`, 3'b001: background colour (blue).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  draw request, single-cycle pulse.
- `row`  in  3  cell row; 0 = top, 5 = bottom.
- `column`  in  3  cell column; 0 = left, 6 = right.
- `player`  in  1  selects `COL_P0` or `COL_P1`.
- `clear`  in  1  board-clear request, level or pulse.
- `x`  out  8  pixel x (160-wide screen).
- `y`  out  7  pixel y (120-high screen).
- `colour`  out  3  pixel colour.
- `plot`  out  1  pixel write strobe.
- `busy`  out  1  high while drawing or clearing.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
- States: IDLE, DRAW, CLEAR, DONE.
- IDLE to CLEAR on `clear`.
    - `clear` wins over a simultaneous `go`; that `go` is dropped.
    - Clear fills with `COL_BG`.
- IDLE to DRAW on `go` with `row` ≤ 5 and `column` ≤ 6.
    - At that edge, latch base x = `X_ORIGIN` + `column`·`CELL_W` and base y = `Y_ORIGIN` + `row`·`CELL_H`.
    - Also latch the colour from `player`.
- A `go` with `row` > 5 or `column` > 6 is ignored: no plot, no `done`.
- `go` and `clear` are ignored while `busy`; they are not queued.
- DRAW scan: offset counters dx (0..`CELL_W`-1) and dy (0..`CELL_H`-1).
    - Row-major order; dx is the inner loop.
    - `x` = base_x + dx, `y` = base_y + dy.
    - `plot` = 1 on every scan cycle.
- CLEAR scan: the same counters sweep dx 0..7·`CELL_W`-1 and dy 0..6·`CELL_H`-1.
    - The scan starts at (`X_ORIGIN`, `Y_ORIGIN`).
- After the last pixel of either scan, go to DONE. DONE asserts `done` for one cycle, then returns to IDLE.
- Arithmetic: all sums are computed at 8 bits for x and 7 bits for y. Default parameters keep every pixel below (136, 108), so no wrap occurs.
- Reset (asynchronous, any state) forces IDLE and zeroes the counters. Output reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0. Any operation in flight is abandoned mid-scan.

## Timing
- `go` sampled at edge N: the first pixel (base_x, base_y) appears with `plot`=1 after edge N+1.
- DRAW holds `plot` high for exactly `CELL_W`·`CELL_H` consecutive cycles (256 with defaults).
- CLEAR holds `plot` high for 42·`CELL_W`·`CELL_H` cycles (10752 with defaults).
- `done` is high the cycle after the last `plot`. `busy` is high from edge N+1 through the last `plot` cycle and low during `done`.
- A new `go` is accepted in the cycle after `done`. Minimum issue interval is `CELL_W`·`CELL_H`+2 cycles.
- `x`, `y`, `colour` and `plot` are all registered; no combinational path runs from inputs to outputs.

## Configuration
- `DISC_ROUND_EN` defined:
    - DRAW plots pixels outside the inscribed circle in `COL_BG`. A pixel is inside when (2dx-(`CELL_W`-1))² + (2dy-(`CELL_H`-1))² ≤ `CELL_W`².
    - `plot` stays high for every scan pixel.
    - Cycle counts are unchanged.
- `DISC_ROUND_EN` undefined: DRAW fills the whole square in the player colour. The circle test is not synthesized.
- CLEAR behaviour is identical in both builds.

## Test plan
- Reset mid-DRAW, then `go` with row=5, column=0, player=0:
    - After reset: all outputs 0.
    - After `go`: 256 plots starting at x=24, y=92, ending at x=39, y=107, colour 3'b100.
    - `done` is pulsed once, the cycle after the last plot.
- `go` with row=0, column=6, player=1:
    - First pixel at x=120, y=12; last at x=135, y=27.
    - Colour 3'b110; exactly 256 `plot` cycles.
- `go` with column=7, or with row=6: zero `plot` cycles, `done` stays 0, `busy` stays 0.
- `go` and `clear` in the same cycle:
    - 10752 plots, all colour 3'b001, from (24,12) to (135,107).
    - No player-colour pixel appears.
- Second `go` 10 cycles into a DRAW: ignored; the total for the first draw stays 256 and a single `done` is pulsed.
- With `DISC_ROUND_EN`, `go` with row=0, column=0, player=0:
    - Pixel (24,12) is 3'b001 and pixel (32,20) is 3'b100.
    - 256 `plot` cycles.
